hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline stall/flush controller for the five-stage MIPS core; complements the forwarding path by handling the hazards that forwarding cannot resolve.

- Detects load-use hazards between the ID and EX stages and inserts one bubble.
- Tracks the multi-cycle multiply/divide unit and stalls any ID instruction that touches HI/LO until the result is ready.
- Issues IF/ID and ID/EX flushes on a taken branch resolved in EX.
- Keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MUL_LAT, 4, multiply latency in cycles (legal ≥2)
- DIV_LAT, 32, divide latency in cycles (legal ≥2, ≤2^CNT_W)
- CNT_W, 6, busy-counter width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- rs_ID  in  5  rs of instruction in ID
- rt_ID  in  5  rt of instruction in ID
- use_rs_ID  in  1  ID instruction reads rs
- use_rt_ID  in  1  ID instruction reads rt
- md_use_ID  in  1  ID instruction is mfhi/mflo/mult/div
- rt_EX  in  5  load destination in ID/EX
- MemRead_EX  in  1  EX instruction is a load
- branch_taken_EX  in  1  branch/jump resolved taken in EX
- md_start_EX  in  1  mult/div issuing from EX this cycle
- md_is_div_EX  in  1  1 = divide, 0 = multiply
- pc_write  out  1  PC update enable
- IF_ID_write  out  1  IF/ID register enable
- IF_ID_flush  out  1  zero IF/ID contents
- ID_EX_bubble  out  1  load NOP into ID/EX
- md_busy  out  1  HI/LO result pending
- stall_cycles  out  16  saturating count of stalled cycles

## Operation
- Controls (pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble) are combinational from the inputs and registered state. md_busy and stall_cycles are registered.
- **Load-use (lu):** MemRead_EX && rt_EX≠0 && ((use_rs_ID && rs_ID==rt_EX) || (use_rt_ID && rt_ID==rt_EX)).
- **MD stall (ms):** md_busy && md_use_ID.
- **Priority, highest first:**
  1. rst low: pc_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0.
  2. branch_taken_EX: pc_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=1. This overrides lu and ms.
  3. lu or ms: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0.
  4. Otherwise: pc_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0.
- **State machine `md_state`:**
  - **IDLE → BUSY** on md_start_EX. The counter loads (md_is_div_EX ? DIV_LAT : MUL_LAT) − 1.
  - **BUSY:** the counter decrements each cycle. Transition to IDLE on the edge where the counter goes 1→0.
  - md_start_EX in BUSY is a protocol violation because ID is stalled. If it occurs, the counter reloads and the state stays BUSY.
  - A taken branch does not cancel an in-flight mult/div.
- md_busy = (state==BUSY), i.e. counter≠0.
- stall_cycles increments on every edge where pc_write==0 and rst is high. It holds at 16'hFFFF.
- **Reset values:** md_state=IDLE, counter=0, md_busy=0, stall_cycles=0. Control outputs take the priority-1 values.
- Reset mid-operation aborts the busy sequence; the unit is in IDLE on the next cycle.

## Timing
- lu stalls exactly one cycle. After the edge, ID/EX holds the bubble, MemRead_EX drops, and lu clears. The load value is then forwarded from MEM/WB.
- md_start_EX sampled at edge k gives md_busy=1 in cycles k+1 … k+LAT−1 (LAT−1 cycles) and md_busy=0 at k+LAT. HI/LO is valid at k+LAT.
- An md_use_ID instruction in ID at cycle k+1 stalls LAT−1 cycles and advances at edge k+LAT.
- lu and ms together: one stall per cycle, counted once.
- Branch in the same cycle as ms: flush wins. The stalled ID instruction is discarded, and md_busy continues counting.

## Structure
- Shared package `pipe_pkg` contains:
  - MD state encoding (IDLE=1'b0, BUSY=1'b1)
  - register-zero constant 5'd0
  - default MUL_LAT/DIV_LAT values, shared with the ALU's mult/div block
- Sub-module `md_latency_counter` handles the load/decrement/zero-detect counter and exposes busy.
- The top level holds the hazard compare logic, the output priority mux, and the stall counter.

## Test plan
- **Load-use:** MemRead_EX=1, rt_EX=8, rs_ID=8, use_rs_ID=1 → one cycle with pc_write=0, IF_ID_write=0, ID_EX_bubble=1; normal on the next cycle; stall_cycles=1.
- **Load to $0:** rt_EX=0, rs_ID=0, MemRead_EX=1 → no stall; pc_write=1.
- **Multiply then mflo:** md_start_EX with MUL_LAT=4, then md_use_ID=1 → md_busy high 3 cycles; stall 3 cycles; stall_cycles=3.
- **Divide then mfhi:** DIV_LAT=32 → md_busy high 31 cycles, then clears; stall_cycles=31.
- **Branch during md stall:** branch_taken_EX=1 while md_busy=1 and md_use_ID=1 → IF_ID_flush=1, ID_EX_bubble=1, pc_write=1; md_busy continues to its scheduled clear.
- **Reset mid-divide:** rst low for one cycle at busy counter 20 → md_busy=0, stall_cycles=0, controls at normal values; the next md_start_EX behaves normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: constants shared across the five-stage pipeline.
//   md_state_t       multiply/divide tracker state encoding
//   REG_ZERO         architectural $zero register number
//   MUL_LAT_DEFAULT  multiply latency, shared with the ALU mult/div block
//   DIV_LAT_DEFAULT  divide latency, shared with the ALU mult/div block
package pipe_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         MUL_LAT_DEFAULT = 4;
    localparam int         DIV_LAT_DEFAULT = 32;

endpackage

// File: rtl/md_latency_counter.sv
// md_latency_counter: tracks an in-flight multiply/divide and reports when
// HI/LO is still pending.
//   clk     core clock
//   rst     synchronous active-low reset
//   start   mult/div issuing from EX this cycle
//   is_div  1 = divide, 0 = multiply
//   busy    HI/LO result pending (registered state)
//
// state   | meaning
// --------+---------------------------------------------------
// MD_IDLE | no operation in flight, HI/LO valid
// MD_BUSY | operation in flight, counter holds cycles remaining
module md_latency_counter
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int DIV_LAT = DIV_LAT_DEFAULT,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start while already busy is a protocol violation upstream; the
    // newest operation wins and the counter simply reloads.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = MD_BUSY;
            cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
        end else if (state_q == MD_BUSY) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = MD_IDLE;
            end
        end
    end

    always_comb begin
        busy = (state_q == MD_BUSY);
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/flush controller for the five-stage core. Covers
// the hazards forwarding cannot: load-use, pending HI/LO, taken branches.
//   clk, rst                 core clock, synchronous active-low reset
//   rs_ID, rt_ID             source registers of the ID instruction
//   use_rs_ID, use_rt_ID     ID instruction actually reads rs / rt
//   md_use_ID                ID instruction touches HI/LO
//   rt_EX, MemRead_EX        load destination / load flag in EX
//   branch_taken_EX          taken branch/jump resolved in EX
//   md_start_EX, md_is_div_EX mult/div issue from EX and its kind
//   pc_write, IF_ID_write    front-end enables (combinational)
//   IF_ID_flush, ID_EX_bubble flush / bubble controls (combinational)
//   md_busy                  HI/LO pending (registered)
//   stall_cycles             saturating stalled-cycle count (registered)
module hazard_stall_unit
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int DIV_LAT = DIV_LAT_DEFAULT,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        use_rs_ID,
    input  logic        use_rt_ID,
    input  logic        md_use_ID,
    input  logic [4:0]  rt_EX,
    input  logic        MemRead_EX,
    input  logic        branch_taken_EX,
    input  logic        md_start_EX,
    input  logic        md_is_div_EX,
    output logic        pc_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_bubble,
    output logic        md_busy,
    output logic [15:0] stall_cycles
);

    logic load_use;
    logic md_stall;

    md_latency_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_cnt (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start_EX),
        .is_div (md_is_div_EX),
        .busy   (md_busy)
    );

    // Loads into $zero never create a real dependency.
    always_comb begin
        load_use = MemRead_EX && (rt_EX != REG_ZERO) &&
                   ((use_rs_ID && (rs_ID == rt_EX)) ||
                    (use_rt_ID && (rt_ID == rt_EX)));
        md_stall = md_busy && md_use_ID;
    end

    // A taken branch discards the ID instruction, so any stall it would
    // have caused is moot; the flush takes precedence.
    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        if (rst) begin
            if (branch_taken_EX) begin
                IF_ID_flush  = 1'b1;
                ID_EX_bubble = 1'b1;
            end else if (load_use || md_stall) begin
                pc_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (!pc_write && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_ID, rt_ID, rt_EX;
    logic        use_rs_ID, use_rt_ID, md_use_ID;
    logic        MemRead_EX, branch_taken_EX, md_start_EX, md_is_div_EX;
    logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, md_busy;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    hazard_stall_unit #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rs_ID           (rs_ID),
        .rt_ID           (rt_ID),
        .use_rs_ID       (use_rs_ID),
        .use_rt_ID       (use_rt_ID),
        .md_use_ID       (md_use_ID),
        .rt_EX           (rt_EX),
        .MemRead_EX      (MemRead_EX),
        .branch_taken_EX (branch_taken_EX),
        .md_start_EX     (md_start_EX),
        .md_is_div_EX    (md_is_div_EX),
        .pc_write        (pc_write),
        .IF_ID_write     (IF_ID_write),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_bubble    (ID_EX_bubble),
        .md_busy         (md_busy),
        .stall_cycles    (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // HI/LO is pending for every cycle index strictly below busy_end.
    int          cyc         = 0;
    int          busy_end    = 0;
    int          m_stall     = 0;
    bit          model_valid = 0;

    function automatic logic [3:0] model_ctrl(input bit busy);
        bit lu, ms;
        lu = MemRead_EX && (rt_EX != 0) &&
             ((use_rs_ID && rs_ID == rt_EX) || (use_rt_ID && rt_ID == rt_EX));
        ms = busy && md_use_ID;
        if (!rst)                return 4'b1100;
        else if (branch_taken_EX) return 4'b1111;
        else if (lu || ms)        return 4'b0001;
        else                      return 4'b1100;
    endfunction

    always @(posedge clk) begin
        logic [3:0] c;
        c = model_ctrl(cyc < busy_end);
        if (!rst) begin
            busy_end    = 0;
            m_stall     = 0;
            model_valid = 1;
        end else begin
            if (!c[3]) m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
            if (md_start_EX) busy_end = cyc + (md_is_div_EX ? DIV_LAT : MUL_LAT);
        end
        cyc++;
    end

    always @(negedge clk) begin
        logic [3:0] c;
        if (model_valid) begin
            c = model_ctrl(cyc < busy_end);
            chk("pc_write",     32'(pc_write),     32'(c[3]));
            chk("IF_ID_write",  32'(IF_ID_write),  32'(c[2]));
            chk("IF_ID_flush",  32'(IF_ID_flush),  32'(c[1]));
            chk("ID_EX_bubble", 32'(ID_EX_bubble), 32'(c[0]));
            chk("md_busy",      32'(md_busy),      32'(cyc < busy_end));
            chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs_ID = 0; rt_ID = 0; rt_EX = 0;
        use_rs_ID = 0; use_rt_ID = 0; md_use_ID = 0;
        MemRead_EX = 0; branch_taken_EX = 0; md_start_EX = 0; md_is_div_EX = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        tick();
        rst = 1;
        #1;
    endtask

    // Counts cycles with md_busy high (md_use_ID held), bounded.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100 && md_busy; i++) begin
            n++;
            tick();
            #1;
        end
    endtask

    typedef struct {
        logic [4:0] rs, rt, rtex;
        logic       urs, urt, mr;
        logic       exp_pcw;
    } lu_vec_t;

    lu_vec_t lu_tab[6] = '{
        '{5'd8,  5'd3,  5'd8,  1'b1, 1'b0, 1'b1, 1'b0},
        '{5'd3,  5'd9,  5'd9,  1'b0, 1'b1, 1'b1, 1'b0},
        '{5'd3,  5'd9,  5'd9,  1'b1, 1'b0, 1'b1, 1'b1},
        '{5'd8,  5'd8,  5'd8,  1'b1, 1'b1, 1'b0, 1'b1},
        '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1},
        '{5'd31, 5'd4,  5'd30, 1'b1, 1'b1, 1'b1, 1'b1}
    };

    initial begin
        int n;
        idle_inputs();
        rst = 0;
        tick();
        tick();
        rst = 1;
        #1;
        chk("reset md_busy", 32'(md_busy), 32'd0);
        chk("reset stall_cycles", 32'(stall_cycles), 32'd0);
        chk("reset pc_write", 32'(pc_write), 32'd1);

        // Load-use on rs.
        do_reset();
        MemRead_EX = 1; rt_EX = 8; rs_ID = 8; use_rs_ID = 1;
        #1;
        chk("lu pc_write", 32'(pc_write), 32'd0);
        chk("lu IF_ID_write", 32'(IF_ID_write), 32'd0);
        chk("lu bubble", 32'(ID_EX_bubble), 32'd1);
        tick();
        MemRead_EX = 0;
        #1;
        chk("lu after pc_write", 32'(pc_write), 32'd1);
        tick();
        chk("lu stall_cycles", 32'(stall_cycles), 32'd1);

        // Load to $0.
        do_reset();
        MemRead_EX = 1; rt_EX = 0; rs_ID = 0; use_rs_ID = 1;
        #1;
        chk("lu0 pc_write", 32'(pc_write), 32'd1);
        tick();
        idle_inputs();
        chk("lu0 stall_cycles", 32'(stall_cycles), 32'd0);

        // Load-use pattern table; the model also checks each cycle.
        foreach (lu_tab[i]) begin
            rs_ID = lu_tab[i].rs; rt_ID = lu_tab[i].rt; rt_EX = lu_tab[i].rtex;
            use_rs_ID = lu_tab[i].urs; use_rt_ID = lu_tab[i].urt;
            MemRead_EX = lu_tab[i].mr;
            #1;
            chk($sformatf("lu_tab[%0d] pc_write", i), 32'(pc_write), 32'(lu_tab[i].exp_pcw));
            tick();
        end
        idle_inputs();

        // Multiply then mflo; a simultaneous load-use is counted once.
        do_reset();
        md_start_EX = 1; md_is_div_EX = 0;
        tick();
        md_start_EX = 0; md_use_ID = 1;
        MemRead_EX = 1; rt_EX = 8; rs_ID = 8; use_rs_ID = 1;
        #1;
        chk("mul+lu pc_write", 32'(pc_write), 32'd0);
        tick();
        MemRead_EX = 0;
        #1;
        count_busy(n);
        chk("mul busy cycles", 32'(n + 1), 32'd3);
        chk("mul advance pc_write", 32'(pc_write), 32'd1);
        tick();
        md_use_ID = 0;
        chk("mul stall_cycles", 32'(stall_cycles), 32'd3);

        // Divide then mfhi.
        do_reset();
        md_start_EX = 1; md_is_div_EX = 1;
        tick();
        md_start_EX = 0; md_is_div_EX = 0; md_use_ID = 1;
        #1;
        count_busy(n);
        chk("div busy cycles", 32'(n), 32'd31);
        tick();
        md_use_ID = 0;
        chk("div stall_cycles", 32'(stall_cycles), 32'd31);

        // Branch during md stall.
        do_reset();
        md_start_EX = 1;
        tick();
        md_start_EX = 0; md_use_ID = 1; branch_taken_EX = 1;
        #1;
        chk("br flush", 32'(IF_ID_flush), 32'd1);
        chk("br bubble", 32'(ID_EX_bubble), 32'd1);
        chk("br pc_write", 32'(pc_write), 32'd1);
        tick();
        branch_taken_EX = 0;
        #1;
        count_busy(n);
        chk("br remaining busy", 32'(n), 32'd2);
        md_use_ID = 0;

        // Reset mid-divide at counter value 20.
        do_reset();
        md_start_EX = 1; md_is_div_EX = 1;
        tick();
        md_start_EX = 0; md_is_div_EX = 0; md_use_ID = 1;
        for (int i = 0; i < 11; i++) tick();
        rst = 0;
        #1;
        chk("rst mid pc_write", 32'(pc_write), 32'd1);
        chk("rst mid bubble", 32'(ID_EX_bubble), 32'd0);
        tick();
        rst = 1; md_use_ID = 0;
        #1;
        chk("rst mid md_busy", 32'(md_busy), 32'd0);
        chk("rst mid stall_cycles", 32'(stall_cycles), 32'd0);
        md_start_EX = 1;
        tick();
        md_start_EX = 0; md_use_ID = 1;
        #1;
        count_busy(n);
        chk("post-rst mul busy", 32'(n), 32'd3);
        md_use_ID = 0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
